pwm_decoder: RTL and testbench



---
 rtl/pwm_decoder_pkg.sv | 28 ++
 rtl/pwm_decoder_edge_sync.sv | 38 +++
 rtl/pwm_decoder.sv | 167 ++++++++++++++++
 tb/tb_pwm_decoder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_decoder_pkg.sv
// Shared constants and FSM encoding for the PWM generator/decoder pair.
// Both ends use these defaults so that encode and decode scale together.
package pwm_decoder_pkg;

    localparam int unsigned STEP_CYCLES_DEF    = 100;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 4000;
    localparam int unsigned CNT_W_DEF          = 12;
    localparam int unsigned CODE_W             = 4;
    localparam int unsigned ACC_W              = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    // Clamp the width accumulator to the largest representable code.
    function automatic logic [CODE_W-1:0] sat_code(input logic [ACC_W-1:0] acc);
        logic [CODE_W-1:0] code;
        if (acc > ACC_W'(15)) begin
            code = CODE_W'(15);
        end else begin
            code = CODE_W'(acc);
        end
        return code;
    endfunction

endpackage

// File: rtl/pwm_decoder_edge_sync.sv
// Two-flop synchroniser with a history flop; reports the synchronised
// level plus single-cycle rise and fall pulses.
module pwm_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic hist_q,  hist_d;

    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
        end
    end

    assign level  = sync2_q;
    assign rise_c = sync2_q & ~hist_q;
    assign fall_c = ~sync2_q & hist_q;

endmodule

// File: rtl/pwm_decoder.sv
// PWM receiver: measures high time and period of an asynchronous PWM line,
// recovers the width code and flags a line that has stopped toggling.
module pwm_decoder
    import pwm_decoder_pkg::*;
#(
    parameter int unsigned STEP_CYCLES    = STEP_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned CNT_W          = CNT_W_DEF
) (
    input  logic              clk_1MHz,
    input  logic              rst_n,
    input  logic              pwm_signal,
    output logic [CODE_W-1:0] pulse_width,
    output logic [CNT_W-1:0]  period_cycles,
    output logic              valid,
    output logic              stuck
);

    localparam int unsigned      PRESC_W    = $clog2(STEP_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] TO_VAL     = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    // high_cnt starts at 1, so the half-step rounding offset starts one ahead.
    localparam logic [PRESC_W-1:0] PRESC_LOAD = PRESC_W'(STEP_CYCLES / 2 + 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_CYCLES - 1);
    localparam logic [ACC_W-1:0]   ACC_MAX    = '1;

    logic level, rise, fall, any_edge, timeout_hit;

    state_e             state_q,  state_d;
    logic [CNT_W-1:0]   high_q,   high_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   idle_q,   idle_d;
    logic [PRESC_W-1:0] presc_q,  presc_d;
    logic [ACC_W-1:0]   acc_q,    acc_d;
    logic [CODE_W-1:0]  pw_q,     pw_d;
    logic [CNT_W-1:0]   per_out_q, per_out_d;
    logic               valid_q,  valid_d;
    logic               stuck_q,  stuck_d;

    pwm_edge_sync u_sync (
        .clk      (clk_1MHz),
        .rst_n    (rst_n),
        .async_in (pwm_signal),
        .level    (level),
        .rise_c   (rise),
        .fall_c   (fall)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign any_edge    = rise | fall;
    assign timeout_hit = ~any_edge && (idle_q == TO_LAST);

    // Next-state, measurement counters and output capture.
    always_comb begin
        state_d   = state_q;
        high_d    = high_q;
        period_d  = period_q;
        idle_d    = idle_q;
        presc_d   = presc_q;
        acc_d     = acc_q;
        pw_d      = pw_q;
        per_out_d = per_out_q;
        valid_d   = 1'b0;
        stuck_d   = stuck_q;

        // Parks at TO_VAL after a timeout so the strobe fires once per episode.
        if (any_edge) begin
            idle_d = '0;
        end else if (idle_q < TO_VAL) begin
            idle_d = idle_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    high_d   = CNT_W'(1);
                    period_d = CNT_W'(1);
                    presc_d  = PRESC_LOAD;
                    acc_d    = '0;
                    state_d  = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (rise) begin
                    state_d = ST_IDLE;
                end else begin
                    period_d = sat_inc(period_q);
                    if (fall) begin
                        state_d = ST_LOW;
                    end else begin
                        high_d = sat_inc(high_q);
                        if (presc_q == PRESC_LAST) begin
                            presc_d = '0;
                            if (acc_q != ACC_MAX) begin
                                acc_d = acc_q + ACC_W'(1);
                            end
                        end else begin
                            presc_d = presc_q + PRESC_W'(1);
                        end
                    end
                end
            end
            ST_LOW: begin
                if (rise) begin
                    per_out_d = period_q;
                    pw_d      = sat_code(acc_q);
                    valid_d   = 1'b1;
                    stuck_d   = 1'b0;
                    high_d    = CNT_W'(1);
                    period_d  = CNT_W'(1);
                    presc_d   = PRESC_LOAD;
                    acc_d     = '0;
                    state_d   = ST_HIGH;
                end else begin
                    period_d = sat_inc(period_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (timeout_hit) begin
            stuck_d   = 1'b1;
            valid_d   = 1'b1;
            per_out_d = '0;
            pw_d      = level ? CODE_W'(15) : CODE_W'(0);
            state_d   = ST_IDLE;
        end
    end

    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            high_q    <= '0;
            period_q  <= '0;
            idle_q    <= '0;
            presc_q   <= '0;
            acc_q     <= '0;
            pw_q      <= '0;
            per_out_q <= '0;
            valid_q   <= 1'b0;
            stuck_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            high_q    <= high_d;
            period_q  <= period_d;
            idle_q    <= idle_d;
            presc_q   <= presc_d;
            acc_q     <= acc_d;
            pw_q      <= pw_d;
            per_out_q <= per_out_d;
            valid_q   <= valid_d;
            stuck_q   <= stuck_d;
        end
    end

    assign pulse_width   = pw_q;
    assign period_cycles = per_out_q;
    assign valid         = valid_q;
    assign stuck         = stuck_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder: strobes are logged by a monitor and each
// scenario task compares the log against hand-computed values.
module tb_pwm_decoder;

    logic        clk_1MHz = 1'b0;
    logic        rst_n;
    logic        pwm_signal;
    logic [3:0]  pulse_width;
    logic [11:0] period_cycles;
    logic        valid;
    logic        stuck;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int pw;
        int per;
        bit st;
    } strobe_t;

    strobe_t sq[$];
    int      dbl = 0;
    logic    prev_valid = 1'b0;

    pwm_decoder dut (
        .clk_1MHz      (clk_1MHz),
        .rst_n         (rst_n),
        .pwm_signal    (pwm_signal),
        .pulse_width   (pulse_width),
        .period_cycles (period_cycles),
        .valid         (valid),
        .stuck         (stuck)
    );

    always #500 clk_1MHz = ~clk_1MHz;

    always @(negedge clk_1MHz) begin
        if (valid === 1'b1) begin
            sq.push_back('{int'(pulse_width), int'(period_cycles), stuck});
            if (prev_valid === 1'b1) dbl++;
        end
        prev_valid = valid;
    end

    task automatic do_reset();
        pwm_signal = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk_1MHz);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_1MHz);
        sq.delete();
        dbl = 0;
    endtask

    task automatic run(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            pwm_signal = 1'b1;
            repeat (h) @(negedge clk_1MHz);
            pwm_signal = 1'b0;
            repeat (l) @(negedge clk_1MHz);
        end
    endtask

    task automatic settle();
        pwm_signal = 1'b1;
        repeat (6) @(negedge clk_1MHz);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pulse_width !== 4'd0) begin failures++; $display("FAIL reset_pw got=%0d exp=0", pulse_width); end
        checks++; if (period_cycles !== 12'd0) begin failures++; $display("FAIL reset_period got=%0d exp=0", period_cycles); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (stuck !== 1'b0) begin failures++; $display("FAIL reset_stuck got=%b exp=0", stuck); end
    endtask

    task automatic test_nominal();
        do_reset();
        run(500, 1500, 3);
        settle();
        checks++; if (sq.size() !== 3) begin failures++; $display("FAIL nominal_count got=%0d exp=3", sq.size()); end
        foreach (sq[i]) begin
            checks++;
            if (sq[i].pw !== 5 || sq[i].per !== 2000 || sq[i].st !== 1'b0) begin
                failures++;
                $display("FAIL nominal_strobe%0d got pw=%0d per=%0d st=%0d exp pw=5 per=2000 st=0", i, sq[i].pw, sq[i].per, sq[i].st);
            end
        end
        checks++; if (dbl !== 0) begin failures++; $display("FAIL nominal_one_cycle got=%0d exp=0", dbl); end
    endtask

    task automatic test_quantise();
        int hs[3] = '{549, 550, 1600};
        int ls[3] = '{451, 450, 400};
        int ex[3] = '{5, 6, 15};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            run(hs[k], ls[k], 2);
            settle();
            checks++; if (sq.size() !== 2) begin failures++; $display("FAIL quant%0d_count got=%0d exp=2", k, sq.size()); end
            foreach (sq[i]) begin
                checks++;
                if (sq[i].pw !== ex[k] || sq[i].per !== hs[k] + ls[k]) begin
                    failures++;
                    $display("FAIL quant%0d_strobe%0d got pw=%0d per=%0d exp pw=%0d per=%0d", k, i, sq[i].pw, sq[i].per, ex[k], hs[k] + ls[k]);
                end
            end
        end
    endtask

    task automatic test_code_change();
        int ex[4] = '{3, 3, 12, 12};
        do_reset();
        run(300, 1700, 2);
        run(1200, 800, 2);
        settle();
        checks++; if (sq.size() !== 4) begin failures++; $display("FAIL change_count got=%0d exp=4", sq.size()); end
        foreach (sq[i]) begin
            if (i < 4) begin
                checks++;
                if (sq[i].pw !== ex[i] || sq[i].per !== 2000) begin
                    failures++;
                    $display("FAIL change_strobe%0d got pw=%0d per=%0d exp pw=%0d per=2000", i, sq[i].pw, sq[i].per, ex[i]);
                end
            end
        end
    endtask

    task automatic test_stuck();
        do_reset();
        run(500, 1500, 1);
        pwm_signal = 1'b1;
        repeat (500) @(negedge clk_1MHz);
        pwm_signal = 1'b0;
        repeat (4600) @(negedge clk_1MHz);
        #1;
        checks++; if (sq.size() !== 2) begin failures++; $display("FAIL stuck_low_count got=%0d exp=2", sq.size()); end
        if (sq.size() >= 2) begin
            checks++;
            if (sq[0].pw !== 5 || sq[0].per !== 2000 || sq[0].st !== 1'b0) begin
                failures++; $display("FAIL stuck_pre_strobe got pw=%0d per=%0d st=%0d exp 5/2000/0", sq[0].pw, sq[0].per, sq[0].st);
            end
            checks++;
            if (sq[1].pw !== 0 || sq[1].per !== 0 || sq[1].st !== 1'b1) begin
                failures++; $display("FAIL stuck_low_strobe got pw=%0d per=%0d st=%0d exp 0/0/1", sq[1].pw, sq[1].per, sq[1].st);
            end
        end
        checks++; if (stuck !== 1'b1) begin failures++; $display("FAIL stuck_low_level got=%b exp=1", stuck); end
        repeat (4500) @(negedge clk_1MHz);
        #1;
        checks++; if (sq.size() !== 2) begin failures++; $display("FAIL stuck_single_strobe got=%0d exp=2", sq.size()); end
        pwm_signal = 1'b1;
        repeat (4600) @(negedge clk_1MHz);
        #1;
        checks++; if (sq.size() !== 3) begin failures++; $display("FAIL stuck_high_count got=%0d exp=3", sq.size()); end
        if (sq.size() >= 3) begin
            checks++;
            if (sq[2].pw !== 15 || sq[2].per !== 0 || sq[2].st !== 1'b1) begin
                failures++; $display("FAIL stuck_high_strobe got pw=%0d per=%0d st=%0d exp 15/0/1", sq[2].pw, sq[2].per, sq[2].st);
            end
        end
        pwm_signal = 1'b0;
        repeat (1500) @(negedge clk_1MHz);
        checks++; if (stuck !== 1'b1) begin failures++; $display("FAIL stuck_hold_until_period got=%b exp=1", stuck); end
        run(500, 1500, 2);
        settle();
        checks++; if (sq.size() !== 5) begin failures++; $display("FAIL stuck_resume_count got=%0d exp=5", sq.size()); end
        if (sq.size() >= 5) begin
            for (int i = 3; i < 5; i++) begin
                checks++;
                if (sq[i].pw !== 5 || sq[i].per !== 2000 || sq[i].st !== 1'b0) begin
                    failures++; $display("FAIL stuck_resume_strobe%0d got pw=%0d per=%0d st=%0d exp 5/2000/0", i, sq[i].pw, sq[i].per, sq[i].st);
                end
            end
        end
        checks++; if (stuck !== 1'b0) begin failures++; $display("FAIL stuck_cleared got=%b exp=0", stuck); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run(500, 1500, 1);
        pwm_signal = 1'b1;
        repeat (200) @(negedge clk_1MHz);
        checks++; if (pulse_width !== 4'd5) begin failures++; $display("FAIL rstmid_before got=%0d exp=5", pulse_width); end
        #200;
        rst_n = 1'b0;
        #1;
        checks++; if (pulse_width !== 4'd0) begin failures++; $display("FAIL rstmid_async_pw got=%0d exp=0", pulse_width); end
        checks++; if (period_cycles !== 12'd0) begin failures++; $display("FAIL rstmid_async_period got=%0d exp=0", period_cycles); end
        repeat (3) @(negedge clk_1MHz);
        rst_n = 1'b1;
        sq.delete();
        dbl = 0;
        repeat (297) @(negedge clk_1MHz);
        pwm_signal = 1'b0;
        repeat (1500) @(negedge clk_1MHz);
        run(500, 1500, 2);
        settle();
        checks++; if (sq.size() !== 3) begin failures++; $display("FAIL rstmid_count got=%0d exp=3", sq.size()); end
        if (sq.size() >= 3) begin
            checks++;
            if (sq[0].per <= 0 || sq[0].per >= 2000) begin
                failures++; $display("FAIL rstmid_partial got per=%0d exp 1..1999", sq[0].per);
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (sq[i].pw !== 5 || sq[i].per !== 2000 || sq[i].st !== 1'b0) begin
                    failures++; $display("FAIL rstmid_strobe%0d got pw=%0d per=%0d st=%0d exp 5/2000/0", i, sq[i].pw, sq[i].per, sq[i].st);
                end
            end
        end
    endtask

    task automatic jit_set(input logic v, input int cycles);
        repeat (cycles) @(negedge clk_1MHz);
        if ($urandom_range(1, 0) == 1) #499;
        else #501;
        pwm_signal = v;
    endtask

    task automatic test_jitter();
        do_reset();
        for (int i = 0; i < 21; i++) begin
            jit_set(1'b1, 500);
            jit_set(1'b0, 500);
        end
        repeat (8) @(negedge clk_1MHz);
        #1;
        checks++; if (sq.size() !== 20) begin failures++; $display("FAIL jitter_count got=%0d exp=20", sq.size()); end
        foreach (sq[i]) begin
            checks++;
            if (sq[i].pw !== 5 || sq[i].per < 999 || sq[i].per > 1001) begin
                failures++; $display("FAIL jitter_strobe%0d got pw=%0d per=%0d exp pw=5 per=999..1001", i, sq[i].pw, sq[i].per);
            end
        end
        checks++; if (dbl !== 0) begin failures++; $display("FAIL jitter_one_cycle got=%0d exp=0", dbl); end
    endtask

    initial begin
        rst_n = 1'b0;
        pwm_signal = 1'b0;
        @(negedge clk_1MHz);
        test_reset();
        test_nominal();
        test_quantise();
        test_code_change();
        test_stuck();
        test_reset_mid();
        test_jitter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
